// File: rtl/i2c_txn_arbiter.sv
// Purpose: round-robin arbiter sharing one I2C byte master among NUM_REQ requesters.
// Latency: grant 1 cycle after req is sampled in IDLE; done/err pulse one cycle after master completes or times out.
// Backpressure: requesters hold req until their done/err pulse; at most one transaction in flight.
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 m_rst,
  output logic                 m_rw,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out,
  input  logic [2:0]           m_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] MST_IDLE = 3'd0;
  localparam logic [2:0] MST_DONE = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_COMPLETE, S_ABORT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               seen_done_q, seen_done_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               m_rst_q, m_rst_d;
  logic               m_rw_q, m_rw_d;
  logic [7:0]         m_data_in_q, m_data_in_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign m_rst     = m_rst_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_in_q;

  // Round-robin pick: scan from last_ptr+1 upward; iterating farthest-first lets the nearest hit win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_ptr_q) + i) % NUM_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic; done/err/grant release are set on entry to COMPLETE/ABORT.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_ptr_d  = last_ptr_q;
    to_d        = to_q;
    seen_done_d = seen_done_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    m_rst_d     = m_rst_q;
    m_rw_d      = m_rw_q;
    m_data_in_d = m_data_in_q;

    case (state_q)
      S_IDLE: begin
        m_rst_d = 1'b1;
        if (pick_vld) begin
          winner_d        = pick_idx;
          m_rw_d          = req_rw[pick_idx];
          m_data_in_d     = req_wdata[8*pick_idx +: 8];
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          m_rst_d         = 1'b0;
          to_d            = '0;
          seen_done_d     = 1'b0;
          state_d         = S_LAUNCH;
        end
      end

      S_LAUNCH, S_RUN: begin
        if (to_q == TO_LAST) begin
          err_d[winner_q] = 1'b1;
          gnt_d           = '0;
          busy_d          = 1'b0;
          m_rst_d         = 1'b1;
          last_ptr_d      = winner_q;
          state_d         = S_ABORT;
        end else begin
          to_d = to_q + 1'b1;
          if (m_state == MST_DONE) seen_done_d = 1'b1;
          if (state_q == S_LAUNCH) begin
            if (m_state != MST_IDLE) state_d = S_RUN;
          end else if (seen_done_q && (m_state == MST_IDLE)) begin
            if (m_rw_q) rdata_d = m_data_out;
            done_d[winner_q] = 1'b1;
            gnt_d            = '0;
            busy_d           = 1'b0;
            m_rst_d          = 1'b1;
            last_ptr_d       = winner_q;
            state_d          = S_COMPLETE;
          end
        end
      end

      S_COMPLETE, S_ABORT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset parks the master and silently drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      winner_q    <= '0;
      last_ptr_q  <= IDX_W'(NUM_REQ - 1);
      to_q        <= '0;
      seen_done_q <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      m_rst_q     <= 1'b1;
      m_rw_q      <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_ptr_q  <= last_ptr_d;
      to_q        <= to_d;
      seen_done_q <= seen_done_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      m_rst_q     <= m_rst_d;
      m_rw_q      <= m_rw_d;
      m_data_in_q <= m_data_in_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a small I2C master stand-in.
// Each scenario task drives stimulus and checks outputs one time unit after the clock edge.
// Master stand-in walks 0->1->4->5->0 once released, or sits at state 2 when stuck.
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [7:0]  rdata;
  logic        busy;
  logic        m_rst;
  logic        m_rw;
  logic [7:0]  m_data_in;
  logic [7:0]  m_data_out;
  logic [2:0]  m_state;

  logic        stuck;
  logic [7:0]  model_rdata;
  int          sc;
  int          errors = 0;
  int          checks = 0;

  i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .m_rst(m_rst), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_state(m_state)
  );

  always #5 clk = ~clk;

  assign m_data_out = model_rdata;

  // Master stand-in: steps once per cycle while released, returns to 0 when parked.
  initial begin
    m_state = 3'd0;
    sc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_rst) begin
        m_state = 3'd0;
        sc = 0;
      end else if (stuck) begin
        m_state = 3'd2;
      end else begin
        case (sc)
          0:       m_state = 3'd1;
          1:       m_state = 3'd4;
          2:       m_state = 3'd5;
          default: m_state = 3'd0;
        endcase
        if (sc < 4) sc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: wait for a grant; kind 1: wait for done or err. Gives up after 40 cycles.
  task automatic wait_for(input int kind, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (kind == 0 && gnt != 4'b0) break;
      if (kind == 1 && (done != 4'b0 || err != 4'b0)) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0 || err !== 4'b0) begin errors++; $display("FAIL rst_done_err got=%b/%b exp=0000/0000", done, err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    checks++; if (busy !== 1'b0 || m_rst !== 1'b1) begin errors++; $display("FAIL rst_busy_mrst got=%b/%b exp=0/1", busy, m_rst); end
    checks++; if (m_rw !== 1'b0 || m_data_in !== 8'h00) begin errors++; $display("FAIL rst_mrw_mdata got=%b/%h exp=0/00", m_rw, m_data_in); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0 || m_rst !== 1'b1) begin errors++; $display("FAIL idle_noreq got=%b/%b exp=0000/1", gnt, m_rst); end
  endtask

  task automatic test_single_write();
    int cyc;
    req_rw = 4'b0000; req_wdata = 32'h0000_00A5; req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL w_gnt got=%b exp=0001", gnt); end
    checks++; if (busy !== 1'b1 || m_rst !== 1'b0) begin errors++; $display("FAIL w_busy_mrst got=%b/%b exp=1/0", busy, m_rst); end
    checks++; if (m_rw !== 1'b0 || m_data_in !== 8'hA5) begin errors++; $display("FAIL w_mrw_mdata got=%b/%h exp=0/a5", m_rw, m_data_in); end
    req_wdata = 32'h0000_0011;
    wait_for(1, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL w_latency got=%0d exp=4", cyc); end
    checks++; if (done !== 4'b0001 || err !== 4'b0) begin errors++; $display("FAIL w_done got=%b/%b exp=0001/0000", done, err); end
    checks++; if (gnt !== 4'b0 || m_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL w_release got=%b/%b/%b exp=0000/1/0", gnt, m_rst, busy); end
    req = 4'b0;
    tick();
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL w_one_pulse got=%b exp=0000", done); end
  endtask

  task automatic test_single_read();
    int cyc;
    req_rw = 4'b0100; req_wdata = 32'h0; model_rdata = 8'h3C; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || m_rw !== 1'b1) begin errors++; $display("FAIL r_gnt got=%b/%b exp=0100/1", gnt, m_rw); end
    wait_for(1, cyc);
    checks++; if (done !== 4'b0100 || rdata !== 8'h3C) begin errors++; $display("FAIL r_done got=%b/%h exp=0100/3c", done, rdata); end
    req = 4'b0; model_rdata = 8'hFF;
    repeat (3) tick();
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL r_hold got=%h exp=3c", rdata); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0; req_rw = 4'b0000; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      wait_for(0, cyc);
      checks++; if (gnt !== exp || $countones(gnt) != 1) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, exp); end
      checks++; if (cyc !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_gap%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 1 : 2); end
      if (k == 4) req = 4'b0;
      wait_for(1, cyc);
      checks++; if (done !== exp || err !== 4'b0 || gnt !== 4'b0) begin errors++; $display("FAIL rr_done%0d got=%b/%b/%b exp=%b/0000/0000", k, done, err, gnt, exp); end
    end
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    stuck = 1'b1; req_rw = 4'b1000; model_rdata = 8'h5A; req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_gnt got=%b exp=0010", gnt); end
    wait_for(1, cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL to_latency got=%0d exp=16", cyc); end
    checks++; if (err !== 4'b0010 || done !== 4'b0) begin errors++; $display("FAIL to_err got=%b/%b exp=0010/0000", err, done); end
    checks++; if (m_rst !== 1'b1 || gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_release got=%b/%b/%b exp=1/0000/0", m_rst, gnt, busy); end
    stuck = 1'b0; req = 4'b1000;
    tick();
    checks++; if (err !== 4'b0) begin errors++; $display("FAIL to_one_pulse got=%b exp=0000", err); end
    wait_for(0, cyc);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL to_next_gnt got=%b exp=1000", gnt); end
    wait_for(1, cyc);
    checks++; if (done !== 4'b1000 || rdata !== 8'h5A) begin errors++; $display("FAIL to_next_done got=%b/%h exp=1000/5a", done, rdata); end
    req = 4'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int pulses;
    req_rw = 4'b0100; req_wdata = 32'h0077_0000; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || m_rw !== 1'b1 || m_data_in !== 8'h77) begin errors++; $display("FAIL rs_gnt got=%b/%b/%h exp=0100/1/77", gnt, m_rw, m_data_in); end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin errors++; $display("FAIL rs_vec got=%b/%b/%b exp=0000/0000/0000", gnt, done, err); end
    checks++; if (rdata !== 8'h00 || busy !== 1'b0 || m_rst !== 1'b1) begin errors++; $display("FAIL rs_ctl got=%h/%b/%b exp=00/0/1", rdata, busy, m_rst); end
    checks++; if (m_rw !== 1'b0 || m_data_in !== 8'h00) begin errors++; $display("FAIL rs_master got=%b/%h exp=0/00", m_rw, m_data_in); end
    rst = 1'b0; req_rw = 4'b0000; req_wdata = 32'h0; req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rs_next_gnt got=%b exp=0001", gnt); end
    req = 4'b0;
    pulses = 0;
    cyc = 0;
    while (cyc < 40 && done == 4'b0) begin
      if (err != 4'b0) pulses++;
      tick();
      cyc++;
    end
    checks++; if (done !== 4'b0001 || pulses != 0) begin errors++; $display("FAIL rs_drain got=%b err_cycles=%0d exp=0001/0", done, pulses); end
    tick(); tick();
  endtask

  task automatic test_drop_midrun();
    int cyc;
    int bad;
    req_rw = 4'b0000; req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL dr_gnt got=%b exp=0010", gnt); end
    tick(); tick();
    req = 4'b0;
    wait_for(1, cyc);
    checks++; if (done !== 4'b0010 || err !== 4'b0) begin errors++; $display("FAIL dr_done got=%b/%b exp=0010/0000", done, err); end
    bad = 0;
    repeat (5) begin
      tick();
      if (gnt != 4'b0 || busy != 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL dr_no_regrant got=%0d busy_cycles exp=0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b0; req_rw = 4'b0; req_wdata = 32'h0;
    stuck = 1'b0; model_rdata = 8'h00;
    repeat (2) tick();
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_reset_midrun();
    test_drop_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
